// File: rtl/wb_dat_rr_arbiter.sv
// wb_dat_rr_arbiter: three-master round-robin arbiter for a shared Wishbone RAM data port with ack timeout.
module wb_dat_rr_arbiter #(
  parameter int DW = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu0_cyc_o,
  input  logic          cpu0_we_o,
  input  logic [DW-1:0] cpu0_adr_o,
  input  logic [DW-1:0] cpu0_dat_o,
  output logic [DW-1:0] cpu0_dat_i,
  output logic          cpu0_ack_i,
  input  logic          cpu1_cyc_o,
  input  logic          cpu1_we_o,
  input  logic [DW-1:0] cpu1_adr_o,
  input  logic [DW-1:0] cpu1_dat_o,
  output logic [DW-1:0] cpu1_dat_i,
  output logic          cpu1_ack_i,
  input  logic          cpu2_cyc_o,
  input  logic          cpu2_we_o,
  input  logic [DW-1:0] cpu2_adr_o,
  input  logic [DW-1:0] cpu2_dat_o,
  output logic [DW-1:0] cpu2_dat_i,
  output logic          cpu2_ack_i,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [DW-1:0] wb_adr,
  output logic [DW-1:0] wb_dat_i,
  input  logic [DW-1:0] wb_dat_o,
  input  logic          wb_ack,
  output logic [2:0]    grant,
  output logic          timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;
  state_e state_q;
  logic [1:0] last_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] grant_q;
  logic we_q, terr_q;
  logic [DW-1:0] adr_q, dat_q;
  logic [2:0] req, acks;
  logic [1:0] p1, p2, win, own;
  logic busy, own_cyc, tmo, sel_we;
  logic [DW-1:0] sel_adr, sel_dat, rdat;
  always_comb begin
    req = {cpu2_cyc_o, cpu1_cyc_o, cpu0_cyc_o};
    p1 = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
    p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    win = req[p1] ? p1 : req[p2] ? p2 : last_q;
    sel_we = win == 2'd0 ? cpu0_we_o : win == 2'd1 ? cpu1_we_o : cpu2_we_o;
    sel_adr = win == 2'd0 ? cpu0_adr_o : win == 2'd1 ? cpu1_adr_o : cpu2_adr_o;
    sel_dat = win == 2'd0 ? cpu0_dat_o : win == 2'd1 ? cpu1_dat_o : cpu2_dat_o;
    busy = rst && state_q == BUSY;
    own = grant_q[2] ? 2'd2 : grant_q[1] ? 2'd1 : 2'd0;
    own_cyc = |(grant_q & req);
    // a real ack always beats the timeout, and an abandoned request never times out
    tmo = busy && !wb_ack && own_cyc && cnt_q == CW'(TIMEOUT - 1);
    acks = busy && (wb_ack || tmo) ? grant_q : 3'b000;
    rdat = busy && !tmo ? wb_dat_o : '0;
  end
  assign cpu0_ack_i = acks[0];
  assign cpu1_ack_i = acks[1];
  assign cpu2_ack_i = acks[2];
  assign cpu0_dat_i = grant_q[0] ? rdat : '0;
  assign cpu1_dat_i = grant_q[1] ? rdat : '0;
  assign cpu2_dat_i = grant_q[2] ? rdat : '0;
  assign wb_cyc = busy;
  assign wb_stb = busy;
  assign wb_we = busy && we_q;
  assign wb_adr = rst ? adr_q : '0;
  assign wb_dat_i = rst ? dat_q : '0;
  assign grant = busy ? grant_q : 3'b000;
  assign timeout_err = rst && terr_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q <= 2'd2;
      cnt_q <= '0;
      grant_q <= 3'b000;
      we_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      terr_q <= 1'b0;
    end else begin
      terr_q <= tmo;
      case (state_q)
        IDLE: if (|req) begin
          state_q <= BUSY;
          grant_q <= 3'b001 << win;
          we_q <= sel_we;
          adr_q <= sel_adr;
          dat_q <= sel_dat;
          cnt_q <= '0;
        end
        BUSY: if (wb_ack || !own_cyc || tmo) begin
          state_q <= GAP;
          grant_q <= 3'b000;
          last_q <= own;
        end else cnt_q <= cnt_q + CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_dat_rr_arbiter.sv
// tb_wb_dat_rr_arbiter: directed vector table plus hand sequences for late ack, write, timeout, abort and reset.
module tb_wb_dat_rr_arbiter;
  logic clk = 1'b0, rst;
  logic cpu0_cyc_o, cpu0_we_o, cpu1_cyc_o, cpu1_we_o, cpu2_cyc_o, cpu2_we_o;
  logic [31:0] cpu0_adr_o, cpu0_dat_o, cpu1_adr_o, cpu1_dat_o, cpu2_adr_o, cpu2_dat_o;
  logic [31:0] cpu0_dat_i, cpu1_dat_i, cpu2_dat_i;
  logic cpu0_ack_i, cpu1_ack_i, cpu2_ack_i;
  logic wb_cyc, wb_stb, wb_we, wb_ack, timeout_err;
  logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
  logic [2:0] grant;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic r;
    logic [2:0] req;
    logic ack;
    logic [31:0] rdat;
    logic [2:0] g;
    logic [2:0] acks;
    logic [31:0] adr;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  wb_dat_rr_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu0_cyc_o(cpu0_cyc_o), .cpu0_we_o(cpu0_we_o), .cpu0_adr_o(cpu0_adr_o), .cpu0_dat_o(cpu0_dat_o),
    .cpu0_dat_i(cpu0_dat_i), .cpu0_ack_i(cpu0_ack_i),
    .cpu1_cyc_o(cpu1_cyc_o), .cpu1_we_o(cpu1_we_o), .cpu1_adr_o(cpu1_adr_o), .cpu1_dat_o(cpu1_dat_o),
    .cpu1_dat_i(cpu1_dat_i), .cpu1_ack_i(cpu1_ack_i),
    .cpu2_cyc_o(cpu2_cyc_o), .cpu2_we_o(cpu2_we_o), .cpu2_adr_o(cpu2_adr_o), .cpu2_dat_o(cpu2_dat_o),
    .cpu2_dat_i(cpu2_dat_i), .cpu2_ack_i(cpu2_ack_i),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .grant(grant), .timeout_err(timeout_err)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    end
  endtask
  task automatic drive(input logic r, input logic [2:0] q, input logic a, input logic [31:0] d);
    rst = r;
    {cpu2_cyc_o, cpu1_cyc_o, cpu0_cyc_o} = q;
    wb_ack = a;
    wb_dat_o = d;
    @(negedge clk);
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    cpu0_we_o = 1'b0; cpu0_adr_o = 32'h100; cpu0_dat_o = 32'hA0;
    cpu1_we_o = 1'b0; cpu1_adr_o = 32'h40;  cpu1_dat_o = 32'hB1;
    cpu2_we_o = 1'b1; cpu2_adr_o = 32'h10;  cpu2_dat_o = 32'h12345678;
    tbl[0]  = '{1'b0, 3'b111, 1'b1, 32'h11, 3'b000, 3'b000, 32'h0};
    tbl[1]  = '{1'b0, 3'b111, 1'b1, 32'h11, 3'b000, 3'b000, 32'h0};
    tbl[2]  = '{1'b1, 3'b111, 1'b1, 32'h11, 3'b000, 3'b000, 32'h0};
    tbl[3]  = '{1'b1, 3'b111, 1'b1, 32'h11, 3'b001, 3'b001, 32'h100};
    tbl[4]  = '{1'b1, 3'b111, 1'b1, 32'h22, 3'b000, 3'b000, 32'h0};
    tbl[5]  = '{1'b1, 3'b111, 1'b1, 32'h22, 3'b000, 3'b000, 32'h0};
    tbl[6]  = '{1'b1, 3'b111, 1'b1, 32'h22, 3'b010, 3'b010, 32'h40};
    tbl[7]  = '{1'b1, 3'b111, 1'b1, 32'h33, 3'b000, 3'b000, 32'h0};
    tbl[8]  = '{1'b1, 3'b111, 1'b1, 32'h33, 3'b000, 3'b000, 32'h0};
    tbl[9]  = '{1'b1, 3'b111, 1'b1, 32'h33, 3'b100, 3'b100, 32'h10};
    tbl[10] = '{1'b1, 3'b111, 1'b1, 32'h44, 3'b000, 3'b000, 32'h0};
    tbl[11] = '{1'b1, 3'b111, 1'b1, 32'h44, 3'b000, 3'b000, 32'h0};
    tbl[12] = '{1'b1, 3'b111, 1'b1, 32'h44, 3'b001, 3'b001, 32'h100};
    tbl[13] = '{1'b1, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 32'h0};
    tbl[14] = '{1'b1, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 32'h0};
    tbl[15] = '{1'b1, 3'b000, 1'b1, 32'h55, 3'b000, 3'b000, 32'h0};
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].req, tbl[i].ack, tbl[i].rdat);
      chk($sformatf("v%0d grant", i), grant, tbl[i].g);
      chk($sformatf("v%0d cyc", i), wb_cyc, |tbl[i].g);
      chk($sformatf("v%0d stb", i), wb_stb, |tbl[i].g);
      chk($sformatf("v%0d we", i), wb_we, tbl[i].g == 3'b100);
      chk($sformatf("v%0d acks", i), {cpu2_ack_i, cpu1_ack_i, cpu0_ack_i}, tbl[i].acks);
      if (|tbl[i].g) chk($sformatf("v%0d adr", i), wb_adr, tbl[i].adr);
      chk($sformatf("v%0d dat0", i), cpu0_dat_i, tbl[i].g[0] ? tbl[i].rdat : 32'h0);
      chk($sformatf("v%0d dat1", i), cpu1_dat_i, tbl[i].g[1] ? tbl[i].rdat : 32'h0);
      chk($sformatf("v%0d dat2", i), cpu2_dat_i, tbl[i].g[2] ? tbl[i].rdat : 32'h0);
      chk($sformatf("v%0d terr", i), timeout_err, 1'b0);
      nxt();
    end
    // cpu1 read, RAM acks on the third BUSY cycle
    drive(1'b1, 3'b010, 1'b0, 32'h0); chk("late idle grant", grant, 3'b000); nxt();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'b010, 1'b0, 32'h0);
      chk("late wait grant", grant, 3'b010);
      chk("late wait acks", {cpu2_ack_i, cpu1_ack_i, cpu0_ack_i}, 3'b000);
      chk("late wait adr", wb_adr, 32'h40);
      nxt();
    end
    drive(1'b1, 3'b010, 1'b1, 32'hDEADBEEF);
    chk("late acks", {cpu2_ack_i, cpu1_ack_i, cpu0_ack_i}, 3'b010);
    chk("late dat1", cpu1_dat_i, 32'hDEADBEEF);
    chk("late dat0", cpu0_dat_i, 32'h0);
    nxt();
    drive(1'b1, 3'b000, 1'b1, 32'hDEADBEEF);
    chk("late gap acks", {cpu2_ack_i, cpu1_ack_i, cpu0_ack_i}, 3'b000);
    nxt();
    // cpu2 write held stable through BUSY
    drive(1'b1, 3'b100, 1'b0, 32'h0); nxt();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b100, i == 3, 32'h0);
      chk("wr we", wb_we, 1'b1);
      chk("wr adr", wb_adr, 32'h10);
      chk("wr dat", wb_dat_i, 32'h12345678);
      chk("wr ack2", cpu2_ack_i, i == 3);
      nxt();
    end
    drive(1'b1, 3'b000, 1'b0, 32'h0); chk("wr gap we", wb_we, 1'b0); nxt();
    // cpu0 never acked: 16 BUSY cycles then timeout, next winner cpu1
    drive(1'b1, 3'b001, 1'b0, 32'h0); nxt();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'b011, 1'b0, 32'hCAFE);
      chk($sformatf("to%0d grant", i), grant, 3'b001);
      chk($sformatf("to%0d ack0", i), cpu0_ack_i, i == 15);
      chk($sformatf("to%0d dat0", i), cpu0_dat_i, i == 15 ? 32'h0 : 32'hCAFE);
      chk($sformatf("to%0d terr", i), timeout_err, 1'b0);
      nxt();
    end
    drive(1'b1, 3'b011, 1'b0, 32'h0);
    chk("to gap terr", timeout_err, 1'b1);
    chk("to gap grant", grant, 3'b000);
    chk("to gap ack0", cpu0_ack_i, 1'b0);
    nxt();
    drive(1'b1, 3'b011, 1'b0, 32'h0); chk("to idle terr", timeout_err, 1'b0); nxt();
    drive(1'b1, 3'b011, 1'b1, 32'h0); chk("to rotate grant", grant, 3'b010); nxt();
    drive(1'b1, 3'b000, 1'b0, 32'h0); nxt();
    // cpu1 abandons on its third BUSY cycle
    drive(1'b1, 3'b010, 1'b0, 32'h0); nxt();
    drive(1'b1, 3'b010, 1'b0, 32'h0); nxt();
    drive(1'b1, 3'b010, 1'b0, 32'h0); nxt();
    drive(1'b1, 3'b000, 1'b0, 32'h0);
    chk("abort acks", {cpu2_ack_i, cpu1_ack_i, cpu0_ack_i}, 3'b000);
    chk("abort grant", grant, 3'b010);
    nxt();
    drive(1'b1, 3'b000, 1'b0, 32'h0);
    chk("abort gap cyc", wb_cyc, 1'b0);
    chk("abort gap grant", grant, 3'b000);
    chk("abort terr", timeout_err, 1'b0);
    nxt();
    // reset while BUSY with a RAM ack present
    drive(1'b1, 3'b001, 1'b0, 32'h0); nxt();
    drive(1'b1, 3'b001, 1'b0, 32'h0); chk("rst busy grant", grant, 3'b001); nxt();
    drive(1'b0, 3'b001, 1'b1, 32'h55);
    chk("rst acks", {cpu2_ack_i, cpu1_ack_i, cpu0_ack_i}, 3'b000);
    chk("rst grant", grant, 3'b000);
    chk("rst cyc", wb_cyc, 1'b0);
    chk("rst dat0", cpu0_dat_i, 32'h0);
    chk("rst adr", wb_adr, 32'h0);
    nxt();
    drive(1'b1, 3'b111, 1'b0, 32'h0);
    chk("post rst grant", grant, 3'b000);
    chk("post rst adr", wb_adr, 32'h0);
    chk("post rst wdat", wb_dat_i, 32'h0);
    chk("post rst we", wb_we, 1'b0);
    nxt();
    drive(1'b1, 3'b111, 1'b1, 32'h0); chk("post rst winner", grant, 3'b001); nxt();
    drive(1'b1, 3'b000, 1'b0, 32'h0); nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_dat_rr_arbiter.md
WB_DAT_RR_ARBITER -- requirements
Module: wb_dat_rr_arbiter

Interface
REQ-001 Parameter DW, default 32, data and address width (matches DataWidth).
REQ-002 Parameter TIMEOUT, default 16, maximum cycles a granted transfer waits for slave ack.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low.
REQ-005 cpuN_cyc_o  in  1  (N=0,1,2) master N bus request; held until ack.
REQ-006 cpuN_we_o  in  1  master N write enable.
REQ-007 cpuN_adr_o  in  DW  master N address.
REQ-008 cpuN_dat_o  in  DW  master N write data.
REQ-009 cpuN_dat_i  out  DW  read data returned to master N.
REQ-010 cpuN_ack_i  out  1  transfer-complete strobe to master N.
REQ-011 wb_cyc, wb_stb, wb_we  out  1 each  shared RAM data-port control.
REQ-012 wb_adr, wb_dat_i  out  DW  shared RAM address and write data.
REQ-013 wb_dat_o  in  DW  RAM read data.
REQ-014 wb_ack  in  1  RAM acknowledge.
REQ-015 grant  out  3  one-hot current owner; 3'b000 when idle.
REQ-016 timeout_err  out  1  one-cycle pulse on transfer timeout.

Function
REQ-017 FSM states: IDLE, BUSY, GAP; encoding free.
REQ-018 IDLE: if any cpuN_cyc_o high, select winner by round-robin starting at (last+1) mod 3, go BUSY next edge; else stay IDLE.
REQ-019 Round-robin pointer last: index of most recent winner; reset value 2 so master 0 has first priority.
REQ-020 Winner, we, adr, dat latched into registers on IDLE->BUSY edge; wb_cyc/wb_stb/grant registered, asserted first cycle of BUSY (one-cycle grant latency from request).
REQ-021 BUSY: wb_cyc=wb_stb=1, wb_we/wb_adr/wb_dat_i from latched values; non-owner inputs ignored.
REQ-022 cpuN_ack_i = wb_ack AND grant[N] AND BUSY, combinational; cpuN_dat_i = wb_dat_o for owner, 0 for non-owners.
REQ-023 BUSY with wb_ack=1: go GAP next edge; last <= owner.
REQ-024 GAP: wb_cyc=wb_stb=0, grant=0, no acks; always IDLE next edge (one dead cycle between owners).
REQ-025 Wait counter: cleared on BUSY entry, increments each BUSY cycle without ack; width ceil(log2(TIMEOUT+1)).
REQ-026 Counter reaching TIMEOUT-1 with no ack: next edge go GAP, pulse timeout_err one cycle, assert owner cpuN_ack_i in that same final BUSY cycle with cpuN_dat_i=0, last <= owner.
REQ-027 Owner drops cpuN_cyc_o during BUSY without ack: abort, go GAP next edge, no ack, no timeout_err, last <= owner.
REQ-028 wb_ack while IDLE or GAP: ignored, no master ack.
REQ-029 wb_ack and timeout on same cycle: ack wins, timeout_err stays 0.
REQ-030 Requests arriving during BUSY/GAP are held by masters and arbitrated at next IDLE; no request is lost or queued internally.
REQ-031 Single requester repeatedly: granted every third cycle minimum (IDLE, BUSY, GAP) when RAM acks in first BUSY cycle.

Reset
REQ-032 rst=0 at rising edge: state<=IDLE, last<=2, counter<=0, latched adr/dat/we<=0.
REQ-033 During and after reset edge: wb_cyc=wb_stb=wb_we=0, wb_adr=wb_dat_i=0, grant=0, timeout_err=0, all cpuN_ack_i=0, all cpuN_dat_i=0.
REQ-034 Reset mid-BUSY abandons transfer without ack; a RAM ack arriving that cycle is not forwarded.

Verification
REQ-035 After reset, cpu0,1,2 cyc_o all high, RAM acks each first BUSY cycle -> grants 001,010,100,001 in order, each BUSY separated by IDLE+GAP.
REQ-036 cpu1 read adr=0x40, RAM returns 0xDEADBEEF with ack 2 cycles late -> cpu1_ack_i single pulse with cpu1_dat_i=0xDEADBEEF, cpu0/cpu2 acks stay 0.
REQ-037 cpu2 write adr=0x10 dat=0x12345678 -> wb_we=1, wb_adr=0x10, wb_dat_i=0x12345678 stable for whole BUSY.
REQ-038 cpu0 request, RAM never acks, TIMEOUT=16 -> exactly 16 BUSY cycles, cpu0_ack_i with dat 0 on 16th, timeout_err pulse, next grant rotates to cpu1.
REQ-039 cpu1 drops cyc_o on 3rd BUSY cycle -> GAP next edge, no ack, no timeout_err.
REQ-040 rst low during BUSY with wb_ack high -> no cpu ack, all outputs 0 next cycle, subsequent arbitration starts at cpu0.
